// File: rtl/color_matrix_pkg.sv
// Shared types and helpers for the colour-matrix block: coefficient indexing,
// identity initialisation and the fixed-point round/clip used by every row.
package color_matrix_pkg;

    localparam int AXIS_TUSER_W = 1;
    localparam int AXIS_TID_W   = 8;
    localparam int AXIS_TDEST_W = 4;

    // Row-major index; column ch_num of each row is that row's offset.
    function automatic int coef_idx(input int r, input int c, input int ch_num);
        return r * (ch_num + 1) + c;
    endfunction

    function automatic logic [63:0] identity_coef(input int idx, input int ch_num, input int fract);
        if ((idx / (ch_num + 1)) == (idx % (ch_num + 1)))
            return 64'd1 << fract;
        return '0;
    endfunction

    // Round half up, then drop the fraction bits.
    function automatic logic signed [63:0] round_px(input logic signed [63:0] acc, input int fract);
        return (acc + (64'sd1 <<< (fract - 1))) >>> fract;
    endfunction

    function automatic logic [63:0] clip_px(input logic signed [63:0] v, input int px);
        logic signed [63:0] max_v;
        max_v = (64'sd1 <<< px) - 64'sd1;
        if (v < 0)
            return '0;
        if (v > max_v)
            return max_v;
        return v;
    endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle used for the pixel input and output of color_matrix.
interface axi4_stream_if
    import color_matrix_pkg::*;
#(
    parameter int TDATA_WIDTH = 32
);
    logic                       tvalid;
    logic                       tready;
    logic [TDATA_WIDTH-1:0]     tdata;
    logic                       tlast;
    logic [AXIS_TUSER_W-1:0]    tuser;
    logic [TDATA_WIDTH/8-1:0]   tkeep;
    logic [TDATA_WIDTH/8-1:0]   tstrb;
    logic [AXIS_TID_W-1:0]      tid;
    logic [AXIS_TDEST_W-1:0]    tdest;

    modport master (output tvalid, tdata, tlast, tuser, tkeep, tstrb, tid, tdest, input tready);
    modport slave  (input tvalid, tdata, tlast, tuser, tkeep, tstrb, tid, tdest, output tready);
endinterface

// File: rtl/color_matrix_row.sv
// One output component: multiply (stage 1), sum with offset (stage 2),
// round and clip (stage 3). All rows share the top-level advance strobe.
module color_matrix_row
    import color_matrix_pkg::*;
#(
    parameter int PX_WIDTH    = 10,
    parameter int FRACT_WIDTH = 10,
    parameter int COEF_WIDTH  = 17,
    parameter int CH_NUM      = 3
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             i_adv,
    input  logic [CH_NUM-1:0][PX_WIDTH-1:0]  i_pix,
    input  logic [CH_NUM:0][COEF_WIDTH-1:0]  i_coef,
    output logic [PX_WIDTH-1:0]              o_pix
);
    localparam int PROD_W = PX_WIDTH + 1 + COEF_WIDTH;
    localparam int ACC_W  = PROD_W + $clog2(CH_NUM + 1);

    logic signed [PROD_W-1:0] r_prod [CH_NUM];
    logic signed [PROD_W-1:0] r_off;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [ACC_W-1:0]  w_sum;
    logic [PX_WIDTH-1:0]      r_pix;

    always_comb begin
        w_sum = ACC_W'(r_off);
        for (int k = 0; k < CH_NUM; k++)
            w_sum = w_sum + ACC_W'(r_prod[k]);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < CH_NUM; k++)
                r_prod[k] <= '0;
            r_off <= '0;
            r_acc <= '0;
            r_pix <= '0;
        end else if (i_adv) begin
            // Pixels are unsigned; a zero sign bit keeps the product exact.
            for (int k = 0; k < CH_NUM; k++)
                r_prod[k] <= PROD_W'($signed({1'b0, i_pix[k]})) * PROD_W'($signed(i_coef[k]));
            r_off <= PROD_W'($signed(i_coef[CH_NUM]));
            r_acc <= w_sum;
            r_pix <= PX_WIDTH'(clip_px(round_px(64'(r_acc), FRACT_WIDTH), PX_WIDTH));
        end
    end

    assign o_pix = r_pix;

endmodule

// File: rtl/color_matrix.sv
// 3-stage colour-space matrix over AXI4-Stream with a writable coefficient bank.
// Define COLOR_MATRIX_SHADOW_EN to stage writes in a shadow bank applied on tuser.
module color_matrix
    import color_matrix_pkg::*;
#(
    parameter int PX_WIDTH    = 10,
    parameter int FRACT_WIDTH = 10,
    parameter int INT_WIDTH   = 6,
    parameter int CH_NUM      = 3,
    localparam int COEF_WIDTH = 1 + INT_WIDTH + FRACT_WIDTH,
    localparam int NCOEF      = CH_NUM * (CH_NUM + 1),
    localparam int SEL_W      = $clog2(NCOEF)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  coef_we_i,
    input  logic [SEL_W-1:0]      coef_sel_i,
    input  logic [COEF_WIDTH-1:0] coef_i,
    output logic [COEF_WIDTH-1:0] coef_rd_o,
    axi4_stream_if.slave          video_i,
    axi4_stream_if.master         video_o
);
    localparam int TDATA_W = ((CH_NUM * PX_WIDTH + 7) / 8) * 8;
    localparam int KEEP_W  = TDATA_W / 8;

    typedef struct packed {
        logic                    last;
        logic [AXIS_TUSER_W-1:0] user;
        logic [KEEP_W-1:0]       keep;
        logic [KEEP_W-1:0]       strb;
        logic [AXIS_TID_W-1:0]   id;
        logic [AXIS_TDEST_W-1:0] dest;
    } side_t;

    logic [NCOEF-1:0][COEF_WIDTH-1:0]  r_act;
    logic [NCOEF-1:0][COEF_WIDTH-1:0]  w_coef_use;
    logic [COEF_WIDTH-1:0]             r_rd;
    logic [2:0]                        r_vld;
    side_t [2:0]                       r_side;
    side_t                             w_side_in;
    logic [CH_NUM-1:0][PX_WIDTH-1:0]   w_pix;
    logic [CH_NUM-1:0][PX_WIDTH-1:0]   w_out;
    logic                              w_adv;
    logic                              w_sel_ok;

    assign w_adv    = !r_vld[2] || video_o.tready;
    assign w_sel_ok = int'(coef_sel_i) < NCOEF;

`ifdef COLOR_MATRIX_SHADOW_EN
    logic [NCOEF-1:0][COEF_WIDTH-1:0] r_shd;
    logic                             w_sof;

    // The tuser beat itself must already see the freshly promoted set.
    assign w_sof      = w_adv && video_i.tvalid && video_i.tuser[0];
    assign w_coef_use = w_sof ? r_shd : r_act;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NCOEF; i++) begin
                r_act[i] <= COEF_WIDTH'(identity_coef(i, CH_NUM, FRACT_WIDTH));
                r_shd[i] <= COEF_WIDTH'(identity_coef(i, CH_NUM, FRACT_WIDTH));
            end
            r_rd <= '0;
        end else begin
            if (w_sof)
                r_act <= r_shd;
            if (coef_we_i && w_sel_ok)
                r_shd[coef_sel_i] <= coef_i;
            r_rd <= w_sel_ok ? r_shd[coef_sel_i] : '0;
        end
    end
`else
    assign w_coef_use = r_act;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NCOEF; i++)
                r_act[i] <= COEF_WIDTH'(identity_coef(i, CH_NUM, FRACT_WIDTH));
            r_rd <= '0;
        end else begin
            if (coef_we_i && w_sel_ok)
                r_act[coef_sel_i] <= coef_i;
            r_rd <= w_sel_ok ? r_act[coef_sel_i] : '0;
        end
    end
`endif

    assign coef_rd_o = r_rd;

    assign w_side_in = '{last: video_i.tlast, user: video_i.tuser, keep: video_i.tkeep,
                         strb: video_i.tstrb, id: video_i.tid, dest: video_i.tdest};

    // Valids and sideband shift on the same strobe as the row datapaths.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_vld  <= '0;
            r_side <= '0;
        end else if (w_adv) begin
            r_vld  <= {r_vld[1:0], video_i.tvalid};
            r_side <= {r_side[1:0], w_side_in};
        end
    end

    for (genvar k = 0; k < CH_NUM; k++) begin : g_pix
        assign w_pix[k] = video_i.tdata[k*PX_WIDTH +: PX_WIDTH];
    end

    if (TDATA_W > CH_NUM * PX_WIDTH) begin : g_pad
        logic w_unused_pad;
        assign w_unused_pad = ^video_i.tdata[TDATA_W-1:CH_NUM*PX_WIDTH];
    end

    for (genvar r = 0; r < CH_NUM; r++) begin : g_row
        logic [CH_NUM:0][COEF_WIDTH-1:0] w_rc;
        for (genvar c = 0; c <= CH_NUM; c++) begin : g_col
            assign w_rc[c] = w_coef_use[coef_idx(r, c, CH_NUM)];
        end
        color_matrix_row #(
            .PX_WIDTH   (PX_WIDTH),
            .FRACT_WIDTH(FRACT_WIDTH),
            .COEF_WIDTH (COEF_WIDTH),
            .CH_NUM     (CH_NUM)
        ) u_row (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .i_adv (w_adv),
            .i_pix (w_pix),
            .i_coef(w_rc),
            .o_pix (w_out[r])
        );
    end

    assign video_i.tready = w_adv;
    assign video_o.tvalid = r_vld[2];
    assign video_o.tdata  = TDATA_W'(w_out);
    assign video_o.tlast  = r_side[2].last;
    assign video_o.tuser  = r_side[2].user;
    assign video_o.tkeep  = r_side[2].keep;
    assign video_o.tstrb  = r_side[2].strb;
    assign video_o.tid    = r_side[2].id;
    assign video_o.tdest  = r_side[2].dest;

endmodule

// File: tb/tb_color_matrix.sv
// Scoreboard bench for color_matrix (PX=10, FRACT=10, INT=6, CH_NUM=3); honours
// COLOR_MATRIX_SHADOW_EN when the design is built with it.
module tb_color_matrix;

    logic        clk;
    logic        rst;
    logic        coef_we;
    logic [3:0]  coef_sel;
    logic [16:0] coef;
    logic [16:0] coef_rd;
    int          rdy_mode;
    int          n_cmp;
    int          n_err;

    logic [53:0] sb[$];
    logic [31:0] obs[$];
    int          a[3][4];
    int          sh[3][4];

    axi4_stream_if #(.TDATA_WIDTH(32)) vin ();
    axi4_stream_if #(.TDATA_WIDTH(32)) vout ();

    color_matrix #(
        .PX_WIDTH(10), .FRACT_WIDTH(10), .INT_WIDTH(6), .CH_NUM(3)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .coef_we_i (coef_we),
        .coef_sel_i(coef_sel),
        .coef_i    (coef),
        .coef_rd_o (coef_rd),
        .video_i   (vin),
        .video_o   (vout)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            vout.tready = (rdy_mode == 0) ? 1'b1 :
                          (rdy_mode == 1) ? ($urandom_range(0, 99) < 30) : 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++) begin
                a[r][c]  = (r == c) ? 1024 : 0;
                sh[r][c] = (r == c) ? 1024 : 0;
            end
    endfunction

    function automatic logic [31:0] model_out(input logic [31:0] din);
        logic [31:0] o;
        longint      acc;
        o = '0;
        for (int r = 0; r < 3; r++) begin
            acc = longint'(a[r][3]);
            for (int k = 0; k < 3; k++)
                acc += longint'(a[r][k]) * longint'(din[k*10 +: 10]);
            acc = (acc + 512) >>> 10;
            if (acc < 0)
                acc = 0;
            else if (acc > 1023)
                acc = 1023;
            o[r*10 +: 10] = acc[9:0];
        end
        return o;
    endfunction

    // Negedge monitor: pops/compares outputs, pushes expectations, tracks writes.
    always @(negedge clk) begin
        logic [53:0] e;
        logic [53:0] g;
        if (rst) begin
            sb.delete();
            model_reset();
        end else begin
            if (vout.tvalid && vout.tready) begin
                obs.push_back(vout.tdata);
                chk("sb_nonempty", 64'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    g = {vout.tdata, vout.tlast, vout.tuser, vout.tkeep, vout.tstrb, vout.tid, vout.tdest};
                    chk("beat", g, e);
                end
            end
            if (vin.tvalid && vin.tready) begin
`ifdef COLOR_MATRIX_SHADOW_EN
                if (vin.tuser[0])
                    a = sh;
`endif
                sb.push_back({model_out(vin.tdata), vin.tlast, vin.tuser, vin.tkeep,
                              vin.tstrb, vin.tid, vin.tdest});
            end
            if (coef_we && coef_sel < 12) begin
`ifdef COLOR_MATRIX_SHADOW_EN
                sh[coef_sel / 4][coef_sel % 4] = int'($signed(coef));
`else
                a[coef_sel / 4][coef_sel % 4] = int'($signed(coef));
`endif
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic last, input logic user);
        logic acc;
        acc = 0;
        vin.tvalid = 1;
        vin.tdata  = d;
        vin.tlast  = last;
        vin.tuser  = user;
        vin.tkeep  = 4'($urandom_range(0, 15));
        vin.tstrb  = 4'($urandom_range(0, 15));
        vin.tid    = 8'($urandom_range(0, 255));
        vin.tdest  = 4'($urandom_range(0, 15));
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            acc = vin.tready;
            @(posedge clk);
            #1;
            if (acc)
                break;
        end
        if (!acc)
            chk("accept_timeout", 64'(acc), 1);
        vin.tvalid = 0;
    endtask

    task automatic wr_coef(input int idx, input int val);
        coef_we  = 1;
        coef_sel = 4'(idx);
        coef     = 17'(val);
        @(posedge clk);
        #1;
        coef_we  = 0;
    endtask

    task automatic rd_coef(input string tag, input int idx, input logic [16:0] exp);
        coef_sel = 4'(idx);
        @(posedge clk);
        @(negedge clk);
        chk(tag, coef_rd, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int t = 0; t < 400; t++) begin
            if (sb.size() == 0)
                break;
            @(negedge clk);
        end
        chk("drain", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic get_obs(output logic [31:0] d);
        d = '0;
        for (int t = 0; t < 50; t++) begin
            if (obs.size() != 0)
                break;
            @(negedge clk);
        end
        if (obs.size() == 0)
            chk("obs_timeout", obs.size(), 1);
        else
            d = obs.pop_front();
    endtask

    function automatic logic [31:0] px3(input int r, input int g, input int b);
        return {2'b00, 10'(b), 10'(g), 10'(r)};
    endfunction

    initial begin
        logic [31:0] d;
        logic [31:0] o;
        int          lat;
        int          seen;
        n_cmp = 0;
        n_err = 0;
        rst = 1;
        rdy_mode = 0;
        coef_we = 0;
        coef_sel = '0;
        coef = '0;
        vin.tvalid = 0; vin.tdata = '0; vin.tlast = 0; vin.tuser = '0;
        vin.tkeep = '0; vin.tstrb = '0; vin.tid = '0; vin.tdest = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tvalid", vout.tvalid, 0);
        chk("rst_tdata", vout.tdata, 0);
        chk("rst_coef_rd", coef_rd, 0);
        @(posedge clk);
        #1;
        rst = 0;
        @(posedge clk);
        #1;

        rd_coef("rd_idx0_reset", 0, 17'h00400);

        // Identity pass-through and latency
        d = px3(100, 200, 300);
        vin.tvalid = 1; vin.tdata = d; vin.tlast = 1; vin.tuser = 1;
        @(posedge clk);
        #1;
        vin.tvalid = 0;
        lat = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (vout.tvalid) begin
                lat = n;
                break;
            end
        end
        chk("latency", lat, 3);
        chk("identity_px", vout.tdata, d);
        @(posedge clk);
        #1;
        drain();

        // Out-of-range index is ignored
        wr_coef(12, 17'h1555);
        rd_coef("rd_idx12", 12, 17'h0);
        rd_coef("rd_idx0_kept", 0, 17'h00400);
        send(px3(7, 8, 9), 0, 1);
        drain();

        // Gain 2.0, offset -10.0 on red: saturate high and low
        wr_coef(0, 2048);
        wr_coef(3, -10240);
        rd_coef("rd_offset", 3, 17'h1D800);
        obs.delete();
        send(px3(600, 1, 2), 0, 1);
        send(px3(3, 1, 2), 0, 0);
        send(px3(100, 1, 2), 0, 0);
        drain();
        get_obs(o); chk("r600_clip_hi", o[9:0], 1023);
        get_obs(o); chk("r3_clip_lo", o[9:0], 0);
        get_obs(o); chk("r100_gain", o[9:0], 190);

        // Half gain on green: round half up
        wr_coef(5, 512);
        obs.delete();
        send(px3(0, 3, 0), 0, 1);
        send(px3(0, 5, 0), 0, 0);
        drain();
        get_obs(o); chk("g3_round", o[19:10], 2);
        get_obs(o); chk("g5_round", o[19:10], 3);

        // Mid-frame write of a[0][0]
        obs.delete();
        send(px3(100, 0, 0), 0, 1);
        drain();
        wr_coef(0, 0);
        send(px3(100, 0, 0), 0, 0);
        drain();
        send(px3(100, 0, 0), 1, 1);
        drain();
        get_obs(o); chk("midframe_before", o[9:0], 190);
`ifdef COLOR_MATRIX_SHADOW_EN
        get_obs(o); chk("midframe_held", o[9:0], 190);
`else
        get_obs(o); chk("midframe_applied", o[9:0], 0);
`endif
        get_obs(o); chk("midframe_sof", o[9:0], 0);

        // Random coefficients, continuous input, 30% tready
        for (int i = 0; i < 12; i++)
            wr_coef(i, (i % 4 == 3) ? int'($urandom_range(0, 102400)) - 51200
                                    : int'($urandom_range(0, 4096)) - 2048);
        rdy_mode = 1;
        for (int i = 0; i < 1000; i++) begin
            if (i == 500)
                for (int j = 0; j < 12; j++)
                    wr_coef(j, (j % 4 == 3) ? int'($urandom_range(0, 40960)) - 20480
                                            : int'($urandom_range(0, 3072)) - 1024);
            send($urandom(), (i % 10) == 9, (i % 100) == 0);
        end
        // Bubbles between beats
        for (int i = 0; i < 100; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send($urandom(), (i % 10) == 9, (i % 25) == 0);
        end
        rdy_mode = 0;
        drain();

        // Reset with beats stuck in the pipeline
        rdy_mode = 2;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        send(px3(1, 2, 3), 0, 1);
        send(px3(4, 5, 6), 0, 0);
        send(px3(7, 8, 9), 0, 0);
        vin.tvalid = 1;
        vin.tdata  = px3(10, 11, 12);
        rst = 1;
        #1;
        chk("midrst_tvalid", vout.tvalid, 0);
        chk("midrst_tdata", vout.tdata, 0);
        @(negedge clk);
        vin.tvalid = 0;
        @(posedge clk);
        #1;
        rst = 0;
        rdy_mode = 0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (vout.tvalid)
                seen++;
        end
        chk("post_rst_idle", seen, 0);
        @(posedge clk);
        #1;
        rd_coef("rd_idx0_rerst", 0, 17'h00400);
        obs.delete();
        d = px3(100, 200, 300);
        send(d, 1, 1);
        drain();
        get_obs(o); chk("rerst_identity", o, d);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
